// File: rtl/rast_params_pkg.sv
// Shared rasterizer parameters and types.
// Holds the coordinate format, the iterator state encoding, the one-hot
// subsample rate codes, and the mapping from rate code to sample step.
package rast_params;

  localparam int SIGFIG = 24;  // bits per coordinate/color value (signed fixed point)
  localparam int RADIX  = 10;  // fraction bits; one pixel = 1<<RADIX
  localparam int VERTS  = 3;   // vertices per micropolygon
  localparam int AXIS   = 3;   // axes per vertex
  localparam int COLORS = 3;   // color channels

  typedef logic signed [SIGFIG-1:0] coord_t;
  typedef coord_t vert_t [AXIS];

  typedef enum logic {IDLE, WALK} iter_state_t;

  localparam logic [3:0] SS_1X  = 4'b1000;
  localparam logic [3:0] SS_4X  = 4'b0100;
  localparam logic [3:0] SS_16X = 4'b0010;
  localparam logic [3:0] SS_64X = 4'b0001;

  // Sample pitch for a rate code. Anything that is not a recognised
  // one-hot code falls back to one sample per pixel.
  function automatic coord_t step_from_code(input logic [3:0] code);
    case (code)
      SS_4X:   return coord_t'(1 << (RADIX - 1));
      SS_16X:  return coord_t'(1 << (RADIX - 2));
      SS_64X:  return coord_t'(1 << (RADIX - 3));
      default: return coord_t'(1 << RADIX);
    endcase
  endfunction

endpackage

// File: rtl/iter_next_pos.sv
// Combinational raster-order successor for the box walker.
// Ports:
//   x, y        current sample position
//   ll_x        left edge of the box (row restart column)
//   ur_x, ur_y  inclusive upper-right corner of the box
//   step        sample pitch
//   next_x/y    following sample position (holds current when last)
//   last        current sample is the final one in the box
module iter_next_pos
  import rast_params::*;
(
  input  coord_t x,
  input  coord_t y,
  input  coord_t ll_x,
  input  coord_t ur_x,
  input  coord_t ur_y,
  input  coord_t step,
  output coord_t next_x,
  output coord_t next_y,
  output logic   last
);

  // One guard bit so that stepping past the top of the coordinate range
  // compares as "beyond the box" instead of wrapping negative.
  logic signed [SIGFIG:0] nx_w;
  logic signed [SIGFIG:0] ny_w;
  logic signed [SIGFIG:0] urx_w;
  logic signed [SIGFIG:0] ury_w;

  assign nx_w  = {x[SIGFIG-1], x} + {step[SIGFIG-1], step};
  assign ny_w  = {y[SIGFIG-1], y} + {step[SIGFIG-1], step};
  assign urx_w = {ur_x[SIGFIG-1], ur_x};
  assign ury_w = {ur_y[SIGFIG-1], ur_y};

  always_comb begin
    next_x = x;
    next_y = y;
    last   = 1'b0;
    if (nx_w <= urx_w) begin
      next_x = nx_w[SIGFIG-1:0];
    end else if (ny_w <= ury_w) begin
      next_x = ll_x;
      next_y = ny_w[SIGFIG-1:0];
    end else begin
      last = 1'b1;
    end
  end

endmodule

// File: rtl/bbox_sample_iter.sv
// Bounding-box sample iterator.
// Accepts one triangle with its clamped bounding box and walks every sample
// position inside the box in raster order (x fastest), one beat per cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   tri_in, color_in      triangle vertices and color (latched on accept)
//   box_in                {ur.y, ur.x, ll.y, ll.x}, signed
//   subsamp_in            one-hot subsample rate
//   in_valid / in_ready   upstream handshake (ready only while idle)
//   tri_out, color_out    latched triangle and color
//   sample_out            {y, x} of the current sample
//   out_valid / out_ready downstream handshake
module bbox_sample_iter
  import rast_params::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]   tri_in,
  input  logic [COLORS*SIGFIG-1:0]       color_in,
  input  logic [2*2*SIGFIG-1:0]          box_in,
  input  logic [3:0]                     subsamp_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [VERTS*AXIS*SIGFIG-1:0]   tri_out,
  output logic [COLORS*SIGFIG-1:0]       color_out,
  output logic [2*SIGFIG-1:0]            sample_out,
  output logic                           out_valid,
  input  logic                           out_ready
);

  // box_w: 0 = ll.x, 1 = ll.y, 2 = ur.x, 3 = ur.y
  coord_t box_w [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_box
      assign box_w[gi] = box_in[gi*SIGFIG +: SIGFIG];
    end
  endgenerate

  iter_state_t                   state_reg, state_next;
  logic [VERTS*AXIS*SIGFIG-1:0]  tri_reg;
  logic [COLORS*SIGFIG-1:0]      color_reg;
  coord_t                        ll_x_reg, ur_x_reg, ur_y_reg, step_reg;
  coord_t                        x_reg, y_reg;
  logic                          degen_reg;

  coord_t next_x, next_y;
  logic   last_w;
  logic   walk_done;
  logic   accept;
  logic   advance;

  iter_next_pos u_next (
    .x      (x_reg),
    .y      (y_reg),
    .ll_x   (ll_x_reg),
    .ur_x   (ur_x_reg),
    .ur_y   (ur_y_reg),
    .step   (step_reg),
    .next_x (next_x),
    .next_y (next_y),
    .last   (last_w)
  );

  // An inverted box yields only its ll sample; without the flag an inverted
  // y range with a valid x range would still walk along x.
  assign walk_done = last_w | degen_reg;
  assign accept    = (state_reg == IDLE) && in_valid;
  assign advance   = (state_reg == WALK) && out_ready && !walk_done;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = WALK;
      WALK:    if (out_ready && walk_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tri_reg   <= '0;
      color_reg <= '0;
      ll_x_reg  <= '0;
      ur_x_reg  <= '0;
      ur_y_reg  <= '0;
      step_reg  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      degen_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        tri_reg   <= tri_in;
        color_reg <= color_in;
        ll_x_reg  <= box_w[0];
        ur_x_reg  <= box_w[2];
        ur_y_reg  <= box_w[3];
        step_reg  <= step_from_code(subsamp_in);
        x_reg     <= box_w[0];
        y_reg     <= box_w[1];
        degen_reg <= (box_w[0] > box_w[2]) || (box_w[1] > box_w[3]);
      end else if (advance) begin
        x_reg <= next_x;
        y_reg <= next_y;
      end
    end
  end

  // Ready is derived from state only (plus reset), never from out_ready.
  assign in_ready   = (state_reg == IDLE) && !rst;
  assign out_valid  = (state_reg == WALK);
  assign tri_out    = tri_reg;
  assign color_out  = color_reg;
  assign sample_out = {y_reg, x_reg};

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Directed bench for bbox_sample_iter: raster walks at several rates,
// backpressure, degenerate boxes, reset mid-walk, back-to-back triangles.
module tb_bbox_sample_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic [215:0] tri_in;
  logic [71:0]  color_in;
  logic [95:0]  box_in;
  logic [3:0]   subsamp_in;
  logic         in_valid;
  logic         in_ready;
  logic [215:0] tri_out;
  logic [71:0]  color_out;
  logic [47:0]  sample_out;
  logic         out_valid;
  logic         out_ready;

  int total = 0;
  int bad   = 0;
  logic [215:0] cur_tri;

  bbox_sample_iter dut (
    .clk        (clk),
    .rst        (rst),
    .tri_in     (tri_in),
    .color_in   (color_in),
    .box_in     (box_in),
    .subsamp_in (subsamp_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tri_out    (tri_out),
    .color_out  (color_out),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] mkbox(input int llx, input int lly, input int urx, input int ury);
    return {ury[23:0], urx[23:0], lly[23:0], llx[23:0]};
  endfunction

  task automatic chk_samp(input string tag, input int x, input int y);
    logic [47:0] e;
    e = {y[23:0], x[23:0]};
    chk({tag, ".sample"}, 216'(sample_out), 216'(e));
    chk({tag, ".valid"}, 216'(out_valid), 216'(1'b1));
    chk({tag, ".tri"}, tri_out, cur_tri);
  endtask

  // Consume one beat with out_ready already high.
  task automatic beat(input string tag, input int x, input int y);
    chk_samp(tag, x, y);
    $display("beat %s x=%0d y=%0d", tag, x, y);
    tick();
  endtask

  task automatic load(input logic [215:0] t, input int llx, input int lly,
                      input int urx, input int ury, input logic [3:0] ss);
    tri_in     = t;
    color_in   = t[71:0] ^ 72'hA5;
    box_in     = mkbox(llx, lly, urx, ury);
    subsamp_in = ss;
    in_valid   = 1'b1;
    chk("load.in_ready", 216'(in_ready), 216'(1'b1));
    tick();
    in_valid   = 1'b0;
    cur_tri    = t;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out_valid"}, 216'(out_valid), 216'(1'b0));
    chk({tag, ".in_ready"}, 216'(in_ready), 216'(1'b1));
  endtask

  initial begin
    logic [215:0] tri_a, tri_b, tri_c, tri_d;
    tri_a = {27{8'h11}};
    tri_b = {27{8'h22}};
    tri_c = {27{8'h33}};
    tri_d = {27{8'h44}};
    cur_tri    = '0;
    rst        = 1'b1;
    tri_in     = '0;
    color_in   = '0;
    box_in     = '0;
    subsamp_in = 4'b1000;
    in_valid   = 1'b0;
    out_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst.out_valid", 216'(out_valid), 216'(1'b0));
    chk("rst.in_ready", 216'(in_ready), 216'(1'b0));
    chk("rst.sample", 216'(sample_out), 216'(0));
    chk("rst.tri", tri_out, 216'(0));
    chk("rst.color", 216'(color_out), 216'(0));
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 216'(in_ready), 216'(1'b1));

    // Test 1: 1x walk of a 2x2 pixel box
    load(tri_a, 0, 0, 1024, 1024, 4'b1000);
    chk("t1.color", 216'(color_out), 216'(tri_a[71:0] ^ 72'hA5));
    chk("t1.in_ready_walk", 216'(in_ready), 216'(1'b0));
    beat("t1", 0, 0);
    beat("t1", 1024, 0);
    beat("t1", 0, 1024);
    beat("t1", 1024, 1024);
    chk_idle("t1.end");

    // Test 2: 4x rate, 3x3 samples
    load(tri_b, 0, 0, 1024, 1024, 4'b0100);
    for (int yi = 0; yi < 3; yi++)
      for (int xi = 0; xi < 3; xi++)
        beat("t2", xi * 512, yi * 512);
    chk_idle("t2.end");

    // Test 3: same walk with alternating backpressure
    load(tri_c, 0, 0, 1024, 1024, 4'b0100);
    for (int yi = 0; yi < 3; yi++)
      for (int xi = 0; xi < 3; xi++) begin
        out_ready = 1'b0;
        chk_samp("t3.pre", xi * 512, yi * 512);
        tick();
        chk_samp("t3.held", xi * 512, yi * 512);
        out_ready = 1'b1;
        beat("t3", xi * 512, yi * 512);
      end
    chk_idle("t3.end");

    // Test 4: degenerate boxes emit exactly the ll sample
    load(tri_d, 2048, 0, 1024, 0, 4'b1000);
    beat("t4x", 2048, 0);
    chk_idle("t4x.end");
    load(tri_a, 0, 2048, 1024, 0, 4'b1000);
    beat("t4y", 0, 2048);
    chk_idle("t4y.end");

    // Other rates, fallback code, and the top of the coordinate range
    load(tri_b, 0, 0, 256, 0, 4'b0010);
    beat("r16", 0, 0);
    beat("r16", 256, 0);
    chk_idle("r16.end");
    load(tri_c, 0, 0, 128, 0, 4'b0001);
    beat("r64", 0, 0);
    beat("r64", 128, 0);
    chk_idle("r64.end");
    load(tri_d, 0, 0, 1024, 0, 4'b1100);
    beat("rbad", 0, 0);
    beat("rbad", 1024, 0);
    chk_idle("rbad.end");
    load(tri_a, 8387584, 0, 8388607, 0, 4'b1000);
    beat("xmax", 8387584, 0);
    chk_idle("xmax.end");

    // Test 5: reset after the second sample of a walk
    load(tri_a, 0, 0, 1024, 1024, 4'b1000);
    beat("t5", 0, 0);
    beat("t5", 1024, 0);
    rst = 1'b1;
    tick();
    chk("t5.rst_valid", 216'(out_valid), 216'(1'b0));
    chk("t5.rst_ready", 216'(in_ready), 216'(1'b0));
    chk("t5.rst_sample", 216'(sample_out), 216'(0));
    chk("t5.rst_tri", tri_out, 216'(0));
    rst = 1'b0;
    #1;
    load(tri_b, 4096, 1024, 5120, 1024, 4'b1000);
    beat("t5b", 4096, 1024);
    beat("t5b", 5120, 1024);
    chk_idle("t5b.end");

    // Test 6: negative box, back-to-back triangles
    tri_in     = tri_c;
    color_in   = '0;
    box_in     = mkbox(-1024, -1024, 0, 0);
    subsamp_in = 4'b1000;
    in_valid   = 1'b1;
    tick();
    cur_tri = tri_c;
    tri_in  = tri_d;
    chk("t6.ready_walk", 216'(in_ready), 216'(1'b0));
    beat("t6c", -1024, -1024);
    beat("t6c", 0, -1024);
    beat("t6c", -1024, 0);
    beat("t6c", 0, 0);
    chk_idle("t6.bubble");
    chk("t6.bubble_tri", tri_out, tri_c);
    tick();
    in_valid = 1'b0;
    cur_tri  = tri_d;
    beat("t6d", -1024, -1024);
    beat("t6d", 0, -1024);
    beat("t6d", -1024, 0);
    beat("t6d", 0, 0);
    chk_idle("t6d.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
